alu_cmd_issue: RTL and testbench

//   Command issue stage sitting directly upstream of the combinational simple ALU.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_cmd_issue.sv | 148 ++++++++++++++
 tb/tb_alu_cmd_issue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issue stage: opcode values,
// issue FSM encoding and the command word layout.
package alu_pkg;

  // Opcodes understood by the downstream combinational ALU.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  // Issue FSM: IDLE waits for work, EXEC lets the ALU settle on the
  // registered operands, HOLD presents the captured response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } issue_state_e;

  // A queued command is stored as the concatenation {op, b, a}, with
  // operand A in the least significant WIDTH bits.

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the issue stage. Plain storage with push/pop strobes;
// the caller guarantees no push when full and no pop when empty.
module alu_cmd_fifo #(
  parameter  int DW    = 19,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage write; a push alongside a pop lands behind the current head.
  // NOTE: the storage array has no reset -- occupancy is tracked by r_count,
  // so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; the count separates full from empty.
  // NOTE: sequential state always uses non-blocking assignment so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/alu_cmd_issue.sv
// Command issue stage in front of the combinational ALU. Queues commands,
// drives one at a time onto registered ALU inputs, captures the result a
// cycle later and returns it in order over a valid/ready response port.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int OPW   = 3,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [OPW-1:0]   rsp_op,
  output logic [CW-1:0]    count,
  output logic             busy
);

  localparam int CMD_W = 2 * WIDTH + OPW;

  issue_state_e     r_state;
  issue_state_e     w_next_state;
  logic             w_push;
  logic             w_pop;
  logic             w_capture;
  logic             w_rsp_clear;
  logic             w_cmd_ready;
  logic [CW-1:0]    w_count;
  logic [CMD_W-1:0] w_head;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_carry;
  logic [OPW-1:0]   r_rsp_op;

  // Ready depends only on registered occupancy, never on the pop decision.
  assign w_cmd_ready = (w_count < CW'(DEPTH));
  assign w_push      = cmd_valid && w_cmd_ready;

  alu_cmd_fifo #(
    .DW    (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({cmd_op, cmd_b, cmd_a}),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next state plus pop/capture/clear strobes.
  // NOTE: every output of this block is defaulted first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_rsp_clear  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_count != '0) begin
          w_pop        = 1'b1;
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        w_capture    = 1'b1;
        w_next_state = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          w_rsp_clear = 1'b1;
          if (w_count != '0) begin
            w_pop        = 1'b1;
            w_next_state = EXEC;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ALU operand registers: load only on a pop, otherwise hold steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_pop) begin
      {r_alu_op, r_alu_b, r_alu_a} <= w_head;
    end
  end

  // Response register: capture the settled ALU output, hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_op     <= '0;
    end else if (w_capture) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= alu_result;
      r_rsp_carry  <= alu_carry;
      r_rsp_op     <= r_alu_op;
    end else if (w_rsp_clear) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_op     = r_rsp_op;
  assign count      = w_count;
  assign busy       = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: a behavioural ALU stands in for the
// parent's ALU, and a queue of expected responses (one entry per accepted
// command, removed when its response is taken) serves as the reference.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [OPW-1:0]   cmd_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic [OPW-1:0]   rsp_op;
  logic [CW-1:0]    count;
  logic             busy;

  always #5 clk = ~clk;

  alu_cmd_issue #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_op     (rsp_op),
    .count      (count),
    .busy       (busy)
  );

  // Behavioural ALU: returns {carry, result}; only ADD produces a carry.
  function automatic logic [WIDTH:0] alu_ref(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [OPW-1:0]   op);
    logic [WIDTH-1:0] r;
    case (op)
      ALU_ADD: return {1'b0, a} + {1'b0, b};
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOT: r = ~a;
      ALU_SHL: r = a << 1;
      default: r = a >> 1;
    endcase
    return {1'b0, r};
  endfunction

  always_comb {alu_carry, alu_result} = alu_ref(alu_a, alu_b, alu_op);

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic             carry;
    logic [WIDTH-1:0] result;
  } rsp_t;

  rsp_t             exp_q[$];
  logic [WIDTH-1:0] obs_q[$];
  int               n_checks    = 0;
  int               n_errors    = 0;
  int               n_valid_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, sampled mid-cycle so it sees what the next edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) begin
        check("idle_busy", busy, 0);
        check("idle_count", count, 0);
      end
      if (exp_q.size() < DEPTH)      check("ready_free", cmd_ready, 1);
      if (exp_q.size() == DEPTH + 1) check("ready_full", cmd_ready, 0);
      if (rsp_valid) begin
        n_valid_seen++;
        if (exp_q.size() == 0) begin
          check("stale_rsp", rsp_valid, 0);
        end else begin
          check("rsp_result", rsp_result, exp_q[0].result);
          check("rsp_carry", rsp_carry, exp_q[0].carry);
          check("rsp_op", rsp_op, exp_q[0].op);
          if (rsp_ready) begin
            obs_q.push_back(rsp_result);
            void'(exp_q.pop_front());
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        logic [WIDTH:0] cr;
        cr = alu_ref(cmd_a, cmd_b, cmd_op);
        exp_q.push_back('{op: cmd_op, carry: cr[WIDTH], result: cr[WIDTH-1:0]});
      end
    end
  end

  // Present one command and hold it until accepted (bounded).
  task automatic push_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [OPW-1:0] op);
    bit got;
    got = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; break; end
    end
    if (!got) check("push_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit got;
    got = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
    end
    if (!got) check("rsp_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit got;
    got = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin got = 1; break; end
    end
    if (!got) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [OPW-1:0]   ops [6];
    logic [WIDTH-1:0] exp_order [6];
    int               accepts;
    int               seen_before;
    bit               got;

    ops       = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL};
    exp_order = '{8'd7, 8'd2, 8'd11, 8'd9, 8'd245, 8'd20};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_count", count, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single ADD: response two edges after accept, valid for one cycle.
    rsp_ready = 1'b1;
    push_cmd(8'd10, 8'd3, ALU_ADD);
    check("lat_n0_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("lat_n1_valid", rsp_valid, 0);
    check("lat_n1_alu_a", alu_a, 10);
    check("lat_n1_alu_b", alu_b, 3);
    @(posedge clk); #1;
    check("lat_n2_valid", rsp_valid, 1);
    check("add_result", rsp_result, 13);
    check("add_carry", rsp_carry, 0);
    @(posedge clk); #1;
    check("lat_n3_valid", rsp_valid, 0);

    // ADD with carry out.
    push_cmd(8'd200, 8'd100, ALU_ADD);
    wait_rsp();
    check("addc_result", rsp_result, 44);
    check("addc_carry", rsp_carry, 1);
    check("addc_op", rsp_op, ALU_ADD);
    wait_drain();

    // Backpressure: one held response plus a full queue blocks the sixth command.
    rsp_ready = 1'b0;
    obs_q.delete();
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_a = 8'd10; cmd_b = 8'd3; cmd_op = ops[i]; cmd_valid = 1'b1;
      got = 0;
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        if (cmd_ready) begin got = 1; break; end
      end
      if (!got) break;
      @(posedge clk); #1;
      accepts++;
    end
    @(posedge clk); #1;
    check("bp_accepts", accepts, 5);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_count", count, DEPTH);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_hold", rsp_result, 7);
    rsp_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; break; end
    end
    if (!got) check("bp_shl_accept", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_drain();
    check("bp_rsp_total", obs_q.size(), 6);
    for (int i = 0; i < 6 && i < obs_q.size(); i++) check("bp_order", obs_q[i], exp_order[i]);

    // Simultaneous push and pop with two commands queued.
    rsp_ready = 1'b0;
    push_cmd(8'd1, 8'd2, ALU_ADD);
    push_cmd(8'd50, 8'd8, ALU_SUB);
    push_cmd(8'hf0, 8'h0f, ALU_XOR);
    wait_rsp();
    @(posedge clk); #1;
    check("pp_count_before", count, 2);
    rsp_ready = 1'b1;
    cmd_a = 8'd5; cmd_b = 8'd10; cmd_op = ALU_OR; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("pp_count_after", count, 2);
    wait_drain();

    // Reset with a held response and three queued commands.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(WIDTH'(i + 1), 8'd1, ALU_ADD);
    wait_rsp();
    @(posedge clk); #1;
    check("rst6_count", count, 3);
    check("rst6_valid", rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst6_rsp_valid", rsp_valid, 0);
    check("rst6_count_after", count, 0);
    check("rst6_busy", busy, 0);
    check("rst6_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen_before = n_valid_seen;
    repeat (20) @(posedge clk);
    #1;
    check("rst6_no_stale", n_valid_seen - seen_before, 0);

    // Randomized traffic with random backpressure on both sides.
    for (int c = 0; c < 600; c++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_a     = ($urandom_range(0, 7) == 0) ? 8'hff : WIDTH'($urandom);
      cmd_b     = ($urandom_range(0, 7) == 0) ? 8'hff : WIDTH'($urandom);
      cmd_op    = OPW'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
